// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the MEM-stage request controller.
// Defaults for bus widths and the LR.W/SC.W funct5 encodings.
package cpu_types_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef logic [4:0]          funct5_t;
  typedef logic [DefAddrW-1:0] addr_t;
  typedef logic [DefDataW-1:0] word_t;

  localparam funct5_t LrFunct5 = 5'b00010;
  localparam funct5_t ScFunct5 = 5'b00011;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone,
    StHalt
  } state_t;

endpackage

// File: rtl/link_reg.sv
// LR/SC reservation: a valid bit plus a word address.
// Supports set/clear, local store clear and snoop invalidation.
module link_reg #(
  parameter int unsigned WORD_W = 30
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set,
  input  logic              clear,
  input  logic              store_hit,
  input  logic [WORD_W-1:0] upd_word,
  input  logic [WORD_W-1:0] chk_word,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_word,
  output logic              match
);

  logic              valid_q;
  logic [WORD_W-1:0] word_q;
  logic              snoop_res;
  logic              snoop_upd;

  assign snoop_res = snoop_inv & (snoop_word == word_q);
  assign snoop_upd = snoop_inv & (snoop_word == upd_word);
  // A snoop in the same cycle already counts as lost for a checking SC.
  assign match     = valid_q & (chk_word == word_q) & ~snoop_res;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (set) begin
      // A snoop to the address being reserved beats the LR.
      valid_q <= ~snoop_upd;
      word_q  <= upd_word;
    end else if (clear | snoop_res | (store_hit & (upd_word == word_q))) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_request_ctrl.sv
// MEM-stage controller: issues one dcache request per memory op, holds it
// until dhit, stalls the pipeline, owns the LR/SC reservation and sticky halt.
module mem_request_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter funct5_t     LR_FUNCT5 = LrFunct5,
  parameter funct5_t     SC_FUNCT5 = ScFunct5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              op_valid,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic              atomic,
  input  logic [4:0]        funct5,
  input  logic              halt,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dstore,
  output logic              stall,
  output logic              op_done,
  output logic [DATA_W-1:0] load_data,
  output logic              halt_out
);

  localparam int unsigned WordW = ADDR_W - 2;

  state_t state;
  logic   mem_op;
  logic   is_lr;
  logic   is_sc;
  logic   req_lr;
  logic   req_sc;
  logic   accept;
  logic   res_match;
  logic   unused_snoop_lsb;

  assign mem_op = op_valid & (Mem_Read | Mem_Write);
  assign is_sc  = atomic & (funct5 == SC_FUNCT5) & Mem_Write;
  assign is_lr  = atomic & (funct5 == LR_FUNCT5) & Mem_Read & ~Mem_Write;
  assign accept = (state == StIdle) & mem_op & ~halt;

  assign unused_snoop_lsb = ^snoop_addr[1:0];

  link_reg #(
    .WORD_W (WordW)
  ) u_link_reg (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        ((state == StReq) & dhit & req_lr),
    .clear      (accept & is_sc),
    .store_hit  ((state == StReq) & dhit & dWEN & ~req_sc),
    .upd_word   (daddr[ADDR_W-1:2]),
    .chk_word   (addr[ADDR_W-1:2]),
    .snoop_inv  (snoop_inv),
    .snoop_word (snoop_addr[ADDR_W-1:2]),
    .match      (res_match)
  );

  always_comb begin
    stall = 1'b0;
    unique case (state)
      StIdle:  stall = mem_op;
      StReq:   stall = 1'b1;
      StDone:  stall = 1'b0;
      StHalt:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= StIdle;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      daddr     <= '0;
      dstore    <= '0;
      op_done   <= 1'b0;
      load_data <= '0;
      halt_out  <= 1'b0;
      req_lr    <= 1'b0;
      req_sc    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (op_valid & halt) begin
            state    <= StHalt;
            halt_out <= 1'b1;
          end else if (mem_op) begin
            if (is_sc & ~res_match) begin
              state     <= StDone;
              op_done   <= 1'b1;
              load_data <= {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
              state  <= StReq;
              daddr  <= addr;
              dstore <= store_data;
              // Read+write without atomic resolves to a write.
              dWEN   <= Mem_Write;
              dREN   <= ~Mem_Write;
              req_lr <= is_lr;
              req_sc <= is_sc;
            end
          end
        end
        StReq: begin
          if (dhit) begin
            state   <= StDone;
            dREN    <= 1'b0;
            dWEN    <= 1'b0;
            op_done <= 1'b1;
            if (dREN) begin
              load_data <= dload;
            end else if (req_sc) begin
              load_data <= '0;
            end
          end
        end
        StDone: begin
          state   <= StIdle;
          op_done <= 1'b0;
        end
        StHalt: begin
          state <= StHalt;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed bench for mem_request_ctrl; expected load_data values are queued
// at issue and checked by a monitor on every op_done pulse.
module tb_mem_request_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        op_valid, Mem_Read, Mem_Write, atomic, halt;
  logic [4:0]  funct5;
  logic [31:0] addr, store_data, dload, snoop_addr;
  logic        dhit, snoop_inv;
  logic        dREN, dWEN, stall, op_done, halt_out;
  logic [31:0] daddr, dstore, load_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [4:0] FLr = 5'b00010;
  localparam logic [4:0] FSc = 5'b00011;

  mem_request_ctrl dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .op_valid   (op_valid),
    .Mem_Read   (Mem_Read),
    .Mem_Write  (Mem_Write),
    .atomic     (atomic),
    .funct5     (funct5),
    .halt       (halt),
    .addr       (addr),
    .store_data (store_data),
    .dhit       (dhit),
    .dload      (dload),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .stall      (stall),
    .op_done    (op_done),
    .load_data  (load_data),
    .halt_out   (halt_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion must match the next queued value.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && op_done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_op_done", 32'd1, 32'd0);
      else chk("load_data", load_data, exp_q.pop_front());
    end
  end

  // Issue one op at a negedge; returns at the negedge after DONE (state IDLE).
  task automatic do_op(input logic rd, input logic wr, input logic atm, input logic [4:0] f5,
                       input logic [31:0] a, input logic [31:0] sd, input int dly,
                       input logic [31:0] dl, input logic [31:0] exp_ld, input logic exp_acc,
                       input logic snp_acc, input logic snp_hit, input logic [31:0] sa);
    int n_req;
    op_valid = 1'b1; Mem_Read = rd; Mem_Write = wr; atomic = atm; funct5 = f5;
    addr = a; store_data = sd; snoop_inv = snp_acc; snoop_addr = sa;
    exp_q.push_back(exp_ld);
    #1 chk("stall_on_accept", {31'd0, stall}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    op_valid = 1'b0; snoop_inv = 1'b0;
    if (exp_acc) begin
      chk("daddr", daddr, a);
      chk("dWEN", {31'd0, dWEN}, {31'd0, wr});
      if (wr) chk("dstore", dstore, sd);
      n_req = 0;
      for (int i = 0; i < dly; i++) begin
        if (i > 0) @(negedge CLK);
        if (dREN | dWEN) n_req++;
        if (!stall) chk("stall_in_req", 32'd0, 32'd1);
        dhit = (i == dly - 1); dload = dl;
        snoop_inv = snp_hit & (i == dly - 1);
        @(posedge CLK);
      end
      @(negedge CLK);
      dhit = 1'b0; snoop_inv = 1'b0;
      chk("req_cycles", n_req, dly);
      chk("req_dropped", {30'd0, dREN, dWEN}, 32'd0);
    end else begin
      chk("no_access_done", {29'd0, op_done, dREN, dWEN}, 32'd4);
    end
    chk("stall_in_done", {31'd0, stall}, 32'd0);
    @(negedge CLK);
  endtask

  task automatic snoop_cycle(input logic [31:0] sa);
    snoop_inv = 1'b1; snoop_addr = sa;
    @(posedge CLK);
    @(negedge CLK);
    snoop_inv = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; op_valid = 0; Mem_Read = 0; Mem_Write = 0; atomic = 0; halt = 0;
    funct5 = 0; addr = 0; store_data = 0; dhit = 0; dload = 0; snoop_inv = 0; snoop_addr = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", {26'd0, dREN, dWEN, stall, op_done, halt_out, 1'b0}, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // LW with dhit after 3 cycles
    do_op(1, 0, 0, 5'd0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    // LR then successful SC, then SC again fails (reservation consumed)
    do_op(1, 0, 1, FLr, 32'h200, 32'h0, 1, 32'h11111111, 32'h11111111, 1, 0, 0, 32'h0);
    do_op(0, 1, 1, FSc, 32'h200, 32'h5, 1, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    do_op(0, 1, 1, FSc, 32'h200, 32'h6, 1, 32'h0, 32'h1, 0, 0, 0, 32'h0);
    // matching snoop between LR and SC kills the SC
    do_op(1, 0, 1, FLr, 32'h200, 32'h0, 1, 32'h22, 32'h22, 1, 0, 0, 32'h0);
    snoop_cycle(32'h200);
    do_op(0, 1, 1, FSc, 32'h200, 32'h5, 1, 32'h0, 32'h1, 0, 0, 0, 32'h0);
    // non-matching snoop leaves it intact
    do_op(1, 0, 1, FLr, 32'h200, 32'h0, 2, 32'h33, 32'h33, 1, 0, 0, 32'h0);
    snoop_cycle(32'h204);
    do_op(0, 1, 1, FSc, 32'h201, 32'h7, 1, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    // snoop in the LR's dhit cycle wins
    do_op(1, 0, 1, FLr, 32'h300, 32'h0, 1, 32'h44, 32'h44, 1, 0, 1, 32'h300);
    do_op(0, 1, 1, FSc, 32'h300, 32'h8, 1, 32'h0, 32'h1, 0, 0, 0, 32'h0);
    // local store (Read+Write, non-atomic -> write) clears reservation; load_data kept
    do_op(1, 0, 1, FLr, 32'h400, 32'h0, 1, 32'h55, 32'h55, 1, 0, 0, 32'h0);
    do_op(1, 1, 0, 5'd0, 32'h400, 32'h9, 2, 32'hFFFF0000, 32'h55, 1, 0, 0, 32'h0);
    do_op(0, 1, 1, FSc, 32'h400, 32'h9, 1, 32'h0, 32'h1, 0, 0, 0, 32'h0);
    // snoop arriving with the SC itself
    do_op(1, 0, 1, FLr, 32'h500, 32'h0, 1, 32'h66, 32'h66, 1, 0, 0, 32'h0);
    do_op(0, 1, 1, FSc, 32'h500, 32'h9, 1, 32'h0, 32'h1, 0, 1, 0, 32'h500);

    // reset in the middle of a store request
    do_op(1, 0, 1, FLr, 32'h600, 32'h0, 1, 32'h77, 32'h77, 1, 0, 0, 32'h0);
    op_valid = 1; Mem_Read = 0; Mem_Write = 1; atomic = 0; addr = 32'h700; store_data = 32'h1;
    @(posedge CLK);
    @(negedge CLK);
    op_valid = 0;
    chk("mid_req_dWEN", {31'd0, dWEN}, 32'd1);
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("reset_abort", {28'd0, dREN, dWEN, stall, op_done}, 32'd0);
    chk("reset_abort_ld", load_data, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    do_op(0, 1, 1, FSc, 32'h600, 32'h2, 1, 32'h0, 32'h1, 0, 0, 0, 32'h0);

    // sticky halt
    op_valid = 1; halt = 1; Mem_Read = 0; Mem_Write = 0;
    @(posedge CLK);
    @(negedge CLK);
    halt = 0; Mem_Read = 1; addr = 32'h800;
    for (int i = 0; i < 3; i++) begin
      chk("halt_hold", {29'd0, halt_out, stall, dREN}, 32'd6);
      @(negedge CLK);
    end
    op_valid = 0; Mem_Read = 0;
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("halt_cleared", {30'd0, halt_out, stall}, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
